centroid_packetizer: RTL and testbench

CENTROID_PACKETIZER -- requirements
Module: centroid_packetizer

---
 rtl/centroid_packetizer.sv | 132 +++++++++++++
 tb/tb_centroid_packetizer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_packetizer.sv
// Centroid packetizer: snapshots a set of ball centroids and streams it out as a
// byte packet (HEADER, N, {X_HI, X_LO, Y} per ball, CHECK) over a ready/valid link.
module centroid_packetizer #(
   parameter logic [7:0]  HEADER    = 8'hA5,
   parameter int unsigned NUM_SLOTS = 7
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic [NUM_SLOTS-1:0][8:0]   centroids_x_in,
   input  logic [NUM_SLOTS-1:0][7:0]   centroids_y_in,
   input  logic [2:0]                  num_balls,
   input  logic                        data_valid_in,
   input  logic                        byte_ready_in,
   output logic [7:0]                  byte_out,
   output logic                        byte_valid_out,
   output logic                        busy_out,
   output logic                        dropped_out
);

   typedef enum logic [2:0] {
      StIdle, StHdr, StCnt, StXhi, StXlo, StYb, StChk
   } state_e;

   state_e                      state_q, state_d;
   logic [NUM_SLOTS-1:0][8:0]   x_q, x_d;
   logic [NUM_SLOTS-1:0][7:0]   y_q, y_d;
   logic [2:0]                  n_q, n_d;
   logic [2:0]                  idx_q, idx_d;
   logic [7:0]                  sum_q, sum_d;
   logic                        dropped_q, dropped_d;

   logic                        xfer;
   logic                        capture;
   logic [8:0]                  x_sel;
   logic [7:0]                  y_sel;

   assign x_sel = x_q[idx_q];
   assign y_sel = y_q[idx_q];

   // Byte presented for the current state; IDLE drives zero so reset clears it at once.
   always_comb begin
      byte_out = 8'h00;
      case (state_q)
         StHdr:   byte_out = HEADER;
         StCnt:   byte_out = {5'b0, n_q};
         StXhi:   byte_out = {7'b0, x_sel[8]};
         StXlo:   byte_out = x_sel[7:0];
         StYb:    byte_out = y_sel;
         StChk:   byte_out = sum_q;
         default: byte_out = 8'h00;
      endcase
   end

   assign byte_valid_out = (state_q != StIdle);
   assign busy_out       = (state_q != StIdle);
   assign dropped_out    = dropped_q;
   assign xfer           = byte_valid_out & byte_ready_in;
   // A new set is taken when idle, or back-to-back as the CHECK byte leaves.
   assign capture        = data_valid_in & ((state_q == StIdle) | ((state_q == StChk) & xfer));

   // Next-state, checksum accumulation, slot walk and capture/drop decisions.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      n_d       = n_q;
      idx_d     = idx_q;
      sum_d     = sum_q;
      dropped_d = data_valid_in & busy_out & ~capture;

      if (xfer) begin
         case (state_q)
            StHdr: state_d = StCnt;
            StCnt: begin
               sum_d   = sum_q + byte_out;
               state_d = (n_q == 3'd0) ? StChk : StXhi;
            end
            StXhi: begin
               sum_d   = sum_q + byte_out;
               state_d = StXlo;
            end
            StXlo: begin
               sum_d   = sum_q + byte_out;
               state_d = StYb;
            end
            StYb: begin
               sum_d = sum_q + byte_out;
               // idx_q <= 6 here, so idx_q + 1 never wraps in 3 bits.
               if ((idx_q + 3'd1) < n_q) begin
                  idx_d   = idx_q + 3'd1;
                  state_d = StXhi;
               end else begin
                  state_d = StChk;
               end
            end
            StChk:   state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end

      if (capture) begin
         x_d     = centroids_x_in;
         y_d     = centroids_y_in;
         n_d     = num_balls;
         idx_d   = 3'd0;
         sum_d   = 8'h00;
         state_d = StHdr;
      end
   end

   // State and snapshot registers, cleared asynchronously by reset.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q   <= StIdle;
         x_q       <= '0;
         y_q       <= '0;
         n_q       <= 3'd0;
         idx_q     <= 3'd0;
         sum_q     <= 8'h00;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         n_q       <= n_d;
         idx_q     <= idx_d;
         sum_q     <= sum_d;
         dropped_q <= dropped_d;
      end
   end

endmodule

// File: tb/tb_centroid_packetizer.sv
// Scoreboard bench for centroid_packetizer: expected packet bytes are queued when a
// set is strobed in and compared as each byte transfers.
module tb_centroid_packetizer;

   logic             clk_in;
   logic             rst_in;
   logic [6:0][8:0]  centroids_x_in;
   logic [6:0][7:0]  centroids_y_in;
   logic [2:0]       num_balls;
   logic             data_valid_in;
   logic             byte_ready_in;
   logic [7:0]       byte_out;
   logic             byte_valid_out;
   logic             busy_out;
   logic             dropped_out;

   int               n_checks = 0;
   int               n_errors = 0;
   int               drop_cnt = 0;
   logic [7:0]       exp_q[$];

   centroid_packetizer #(
      .HEADER    (8'hA5),
      .NUM_SLOTS (7)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .centroids_x_in (centroids_x_in),
      .centroids_y_in (centroids_y_in),
      .num_balls      (num_balls),
      .data_valid_in  (data_valid_in),
      .byte_ready_in  (byte_ready_in),
      .byte_out       (byte_out),
      .byte_valid_out (byte_valid_out),
      .busy_out       (busy_out),
      .dropped_out    (dropped_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference packet: HEADER, N, per-slot bytes, then the mod-256 sum after HEADER.
   task automatic push_packet(input logic [2:0] n, input logic [6:0][8:0] xs,
                              input logic [6:0][7:0] ys);
      logic [7:0] sum;
      logic [7:0] b;
      exp_q.push_back(8'hA5);
      b   = {5'b0, n};
      exp_q.push_back(b);
      sum = b;
      for (int i = 0; i < int'(n); i++) begin
         b = {7'b0, xs[i][8]};   exp_q.push_back(b); sum = sum + b;
         b = xs[i][7:0];         exp_q.push_back(b); sum = sum + b;
         b = ys[i];              exp_q.push_back(b); sum = sum + b;
      end
      exp_q.push_back(sum);
   endtask

   // Present a set for one edge, then scramble the inputs so late changes would show.
   task automatic strobe(input logic [2:0] n, input logic [6:0][8:0] xs,
                         input logic [6:0][7:0] ys, input bit push);
      centroids_x_in = xs;
      centroids_y_in = ys;
      num_balls      = n;
      data_valid_in  = 1'b1;
      if (push) push_packet(n, xs, ys);
      @(posedge clk_in); #2;
      data_valid_in  = 1'b0;
      centroids_x_in = 63'({$urandom(), $urandom()});
      centroids_y_in = 56'({$urandom(), $urandom()});
      num_balls      = 3'($urandom());
   endtask

   task automatic step(input int k);
      repeat (k) begin
         @(posedge clk_in); #2;
      end
   endtask

   task automatic wait_idle(input int maxc, input bit rnd, output int cyc);
      cyc = 0;
      while (busy_out && cyc < maxc) begin
         if (rnd) byte_ready_in = 1'($urandom_range(0, 1));
         @(posedge clk_in); #2;
         cyc++;
      end
      byte_ready_in = 1'b1;
      if (busy_out) check("idle_timeout", 32'd1, 32'd0);
   endtask

   // Transfer monitor: every accepted byte must match the head of the scoreboard.
   always @(negedge clk_in) begin
      if (rst_in) begin
         if (dropped_out) drop_cnt++;
         if (byte_valid_out && byte_ready_in) begin
            if (exp_q.size() == 0) check("unexpected_byte", {24'd0, byte_out}, 32'hFFFF_FFFF);
            else check("byte", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [6:0][8:0] xs;
      logic [6:0][7:0] ys;
      logic [2:0]      n;
      int              cyc;
      int              drop_base;

      rst_in         = 1'b0;
      centroids_x_in = '0;
      centroids_y_in = '0;
      num_balls      = 3'd0;
      data_valid_in  = 1'b0;
      byte_ready_in  = 1'b1;
      #12;
      check("rst_valid",   {31'd0, byte_valid_out}, 32'd0);
      check("rst_busy",    {31'd0, busy_out},       32'd0);
      check("rst_byte",    {24'd0, byte_out},       32'd0);
      check("rst_dropped", {31'd0, dropped_out},    32'd0);
      @(posedge clk_in); #2;
      rst_in = 1'b1;
      step(1);
      check("idle_valid", {31'd0, byte_valid_out}, 32'd0);

      // Single ball with literal expected bytes.
      xs = '0; ys = '0; xs[0] = 9'd300; ys[0] = 8'd100;
      foreach (exp_q[i]) ;
      exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'h01);
      exp_q.push_back(8'h2C); exp_q.push_back(8'h64); exp_q.push_back(8'h92);
      strobe(3'd1, xs, ys, 1'b0);
      check("first_valid", {31'd0, byte_valid_out}, 32'd1);
      check("first_hdr",   {24'd0, byte_out},       32'h0000_00A5);
      wait_idle(50, 1'b0, cyc);
      check("single_len", cyc, 32'd6);
      check("single_busy", {31'd0, busy_out}, 32'd0);

      // Zero balls.
      exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      strobe(3'd0, xs, ys, 1'b0);
      wait_idle(50, 1'b0, cyc);
      check("zero_len", cyc, 32'd3);

      // Backpressure during X_LO.
      strobe(3'd1, xs, ys, 1'b1);
      step(3);
      byte_ready_in = 1'b0;
      repeat (3) begin
         @(negedge clk_in); #1;
         check("bp_hold",  {24'd0, byte_out},       32'h0000_002C);
         check("bp_valid", {31'd0, byte_valid_out}, 32'd1);
      end
      @(posedge clk_in); #2;
      byte_ready_in = 1'b1;
      wait_idle(50, 1'b0, cyc);

      // Strobe during YB is dropped.
      drop_base = drop_cnt;
      strobe(3'd1, xs, ys, 1'b1);
      step(4);
      strobe(3'd2, 63'({$urandom(), $urandom()}), 56'({$urandom(), $urandom()}), 1'b0);
      check("drop_pulse", {31'd0, dropped_out}, 32'd1);
      step(1);
      check("drop_once", {31'd0, dropped_out}, 32'd0);
      wait_idle(50, 1'b0, cyc);
      check("drop_count", drop_cnt - drop_base, 32'd1);

      // Strobe coincident with the CHECK transfer: back-to-back packets.
      drop_base = drop_cnt;
      strobe(3'd1, xs, ys, 1'b1);
      step(5);
      xs[1] = 9'd17; ys[1] = 8'd5;
      strobe(3'd2, xs, ys, 1'b1);
      check("b2b_valid",   {31'd0, byte_valid_out}, 32'd1);
      check("b2b_hdr",     {24'd0, byte_out},       32'h0000_00A5);
      check("b2b_dropped", {31'd0, dropped_out},    32'd0);
      wait_idle(50, 1'b0, cyc);
      check("b2b_nodrop", drop_cnt - drop_base, 32'd0);

      // Full set.
      for (int i = 0; i < 7; i++) begin
         xs[i] = 9'(319 - i);
         ys[i] = 8'(179 - i);
      end
      strobe(3'd7, xs, ys, 1'b1);
      wait_idle(100, 1'b0, cyc);
      check("full_len", cyc, 32'd24);

      // Random sets with random backpressure.
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 7; i++) begin
            xs[i] = 9'($urandom_range(0, 319));
            ys[i] = 8'($urandom_range(0, 179));
         end
         n = 3'($urandom_range(0, 7));
         strobe(n, xs, ys, 1'b1);
         wait_idle(400, 1'b1, cyc);
      end

      // Asynchronous reset mid-packet (during X_LO).
      strobe(3'd3, xs, ys, 1'b1);
      step(3);
      #1;
      rst_in = 1'b0;
      #1;
      check("arst_valid", {31'd0, byte_valid_out}, 32'd0);
      check("arst_busy",  {31'd0, busy_out},       32'd0);
      check("arst_byte",  {24'd0, byte_out},       32'd0);
      exp_q.delete();
      @(posedge clk_in); #2;
      rst_in = 1'b1;
      step(3);
      check("post_rst_valid", {31'd0, byte_valid_out}, 32'd0);
      check("post_rst_busy",  {31'd0, busy_out},       32'd0);

      // Strobe on the first edge after reset release is captured.
      rst_in = 1'b0;
      @(posedge clk_in); #2;
      rst_in = 1'b1;
      xs[0] = 9'd300; ys[0] = 8'd100;
      strobe(3'd1, xs, ys, 1'b1);
      check("rel_capture", {31'd0, byte_valid_out}, 32'd1);
      wait_idle(50, 1'b0, cyc);
      check("rel_len", cyc, 32'd6);

      step(2);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
